// File: rtl/intr_sequencer_core.sv
// 8259-style interrupt sequencer: ICW init FSM, rotating priority resolver,
// two-pulse INTA handshake with vector generation and EOI handling.
module intr_sequencer_core #(
  parameter int N_IRQ = 8,
  parameter int IDW   = $clog2(N_IRQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_stb,
  input  logic             a0,
  input  logic [7:0]       wr_data,
  input  logic             inta_stb,
  input  logic [N_IRQ-1:0] irq_req,
  output logic             int_out,
  output logic [7:0]       vector_out,
  output logic             vector_valid,
  output logic [7:0]       rd_data,
  output logic [N_IRQ-1:0] imr_out,
  output logic [N_IRQ-1:0] isr_out,
  output logic [N_IRQ-1:0] irr_out,
  output logic             init_done
);

  typedef enum logic [2:0] {UNINIT, W_ICW2, W_ICW3, W_ICW4, READY} state_t;

  state_t           state;
  logic             ltim, sngl, ic4, aeoi, auto_rotate, ris, inta_phase;
  logic [7-IDW:0]   icw2_hi;
  logic [N_IRQ-1:0] imr, isr, irr, irq_prev, req_masked;
  logic [IDW-1:0]   lowest_prio, ack_id, cand_id, isr_top, ocw_l;
  logic             cand_valid, isr_any, isr_block, icw1, ready;
  logic [IDW-1:0]   rot_idx [N_IRQ];

  // rot_idx[k] is the channel holding priority rank k (0 = highest)
  genvar gi;
  generate
    for (gi = 0; gi < N_IRQ; gi++) begin : g_rot
      assign rot_idx[gi] = lowest_prio + IDW'(gi + 1);
    end
  endgenerate

  assign icw1       = wr_stb && !a0 && wr_data[4];
  assign ready      = (state == READY);
  assign req_masked = irr & ~imr;
  assign ocw_l      = wr_data[IDW-1:0];

  always_comb begin
    isr_any = 1'b0;
    isr_top = '0;
    for (int k = 0; k < N_IRQ; k++) begin
      if (!isr_any && isr[rot_idx[k]]) begin
        isr_any = 1'b1;
        isr_top = rot_idx[k];
      end
    end
  end

  // Scan down the priority order; an in-service channel blocks itself and all below it
  always_comb begin
    cand_valid = 1'b0;
    cand_id    = '0;
    isr_block  = 1'b0;
    for (int k = 0; k < N_IRQ; k++) begin
      if (!cand_valid && !isr_block) begin
        if (isr[rot_idx[k]]) begin
          isr_block = 1'b1;
        end else if (req_masked[rot_idx[k]]) begin
          cand_valid = 1'b1;
          cand_id    = rot_idx[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= UNINIT;
      ltim         <= 1'b0;
      sngl         <= 1'b0;
      ic4          <= 1'b0;
      aeoi         <= 1'b0;
      auto_rotate  <= 1'b0;
      ris          <= 1'b0;
      icw2_hi      <= '0;
      imr          <= '0;
      isr          <= '0;
      irr          <= '0;
      irq_prev     <= '0;
      lowest_prio  <= IDW'(N_IRQ - 1);
      ack_id       <= '0;
      inta_phase   <= 1'b0;
      int_out      <= 1'b0;
      vector_out   <= '0;
      vector_valid <= 1'b0;
    end else begin
      irq_prev     <= irq_req;
      vector_valid <= 1'b0;
      if (icw1) begin
        ltim        <= wr_data[3];
        sngl        <= wr_data[1];
        ic4         <= wr_data[0];
        imr         <= '0;
        isr         <= '0;
        irr         <= '0;
        aeoi        <= 1'b0;
        auto_rotate <= 1'b0;
        lowest_prio <= IDW'(N_IRQ - 1);
        inta_phase  <= 1'b0;
        int_out     <= 1'b0;
        state       <= W_ICW2;
      end else begin
        irr <= ltim ? irq_req : (irr | (irq_req & ~irq_prev));
        if (wr_stb) begin
          case (state)
            W_ICW2: begin
              icw2_hi <= wr_data[7:IDW];
              state   <= !sngl ? W_ICW3 : (ic4 ? W_ICW4 : READY);
            end
            W_ICW3: state <= ic4 ? W_ICW4 : READY;
            W_ICW4: begin
              aeoi  <= wr_data[1];
              state <= READY;
            end
            READY: begin
              if (a0) begin
                imr <= wr_data[N_IRQ-1:0];
              end else if (wr_data[4:3] == 2'b00) begin
                case (wr_data[7:5])
                  3'b001: if (isr_any) isr[isr_top] <= 1'b0;
                  3'b011: if (isr_any) isr[ocw_l] <= 1'b0;
                  3'b101: if (isr_any) begin
                    isr[isr_top] <= 1'b0;
                    lowest_prio  <= isr_top;
                  end
                  3'b111: if (isr_any) begin
                    isr[ocw_l]  <= 1'b0;
                    lowest_prio <= ocw_l;
                  end
                  3'b110: lowest_prio <= ocw_l;
                  3'b100: auto_rotate <= 1'b1;
                  3'b000: auto_rotate <= 1'b0;
                  default: ;
                endcase
              end else if (wr_data[4:3] == 2'b01 && wr_data[1]) begin
                ris <= wr_data[0];
              end
            end
            default: ;
          endcase
        end
        // INTA updates come after the EOI clears so a same-bit set wins
        if (ready && inta_stb) begin
          int_out <= 1'b0;
          if (!inta_phase) begin
            ack_id     <= cand_valid ? cand_id : IDW'(N_IRQ - 1);
            inta_phase <= 1'b1;
            if (cand_valid) begin
              isr[cand_id] <= 1'b1;
              irr[cand_id] <= 1'b0;
            end
          end else begin
            vector_out   <= {icw2_hi, ack_id};
            vector_valid <= 1'b1;
            inta_phase   <= 1'b0;
            if (aeoi) begin
              isr[ack_id] <= 1'b0;
              if (auto_rotate) lowest_prio <= ack_id;
            end
          end
        end else begin
          int_out <= ready && cand_valid && !inta_phase;
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (a0)       rd_data[N_IRQ-1:0] = imr;
    else if (ris) rd_data[N_IRQ-1:0] = isr;
    else          rd_data[N_IRQ-1:0] = irr;
  end

  assign imr_out   = imr;
  assign isr_out   = isr;
  assign irr_out   = irr;
  assign init_done = ready;

endmodule

// File: tb/tb_intr_sequencer_core.sv
// Bench for intr_sequencer_core: directed scenarios plus randomized traffic
// checked every cycle against a rank-based behavioural model.
module tb_intr_sequencer_core;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_stb = 1'b0, a0 = 1'b0, inta_stb = 1'b0;
  logic [7:0] wr_data = '0, irq_req = '0;
  logic       int_out, vector_valid, init_done;
  logic [7:0] vector_out, rd_data, imr_out, isr_out, irr_out;

  logic       wr_stb4 = 1'b0, a0_4 = 1'b0, inta4 = 1'b0;
  logic [7:0] wr_data4 = '0;
  logic [3:0] irq4 = '0;
  logic       int4, vv4, done4;
  logic [7:0] vec4, rd4;
  logic [3:0] imr4, isr4, irr4;

  always #5 clk = ~clk;

  intr_sequencer_core #(.N_IRQ(8)) dut (
    .clk(clk), .reset(reset), .wr_stb(wr_stb), .a0(a0), .wr_data(wr_data),
    .inta_stb(inta_stb), .irq_req(irq_req), .int_out(int_out),
    .vector_out(vector_out), .vector_valid(vector_valid), .rd_data(rd_data),
    .imr_out(imr_out), .isr_out(isr_out), .irr_out(irr_out), .init_done(init_done)
  );

  intr_sequencer_core #(.N_IRQ(4)) dut4 (
    .clk(clk), .reset(reset), .wr_stb(wr_stb4), .a0(a0_4), .wr_data(wr_data4),
    .inta_stb(inta4), .irq_req(irq4), .int_out(int4),
    .vector_out(vec4), .vector_valid(vv4), .rd_data(rd4),
    .imr_out(imr4), .isr_out(isr4), .irr_out(irr4), .init_done(done4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int S_UNINIT = 0, S_W2 = 1, S_W3 = 2, S_W4 = 3, S_RDY = 4;
  int         m_state, m_lp, m_ack;
  logic       m_ltim, m_sngl, m_ic4, m_aeoi, m_rot, m_ris, m_phase, m_int, m_vv;
  logic [7:0] m_icw2, m_imr, m_isr, m_irr, m_prev, m_vec;
  logic [7:0] req_v = '0;

  // rank 0 is the highest priority: the channel right after lowest_prio
  function automatic int rank(input int ch, input int lp);
    return (ch - lp + 7) % 8;
  endfunction

  function automatic int top_isr(input logic [7:0] s, input int lp);
    int best = -1;
    int br = 8;
    for (int i = 0; i < 8; i++)
      if (s[i] && rank(i, lp) < br) begin best = i; br = rank(i, lp); end
    return best;
  endfunction

  function automatic int pick(input logic [7:0] pend, input logic [7:0] s, input int lp);
    int t = top_isr(s, lp);
    int lim = (t < 0) ? 8 : rank(t, lp);
    int best = -1;
    int br = 8;
    for (int i = 0; i < 8; i++)
      if (pend[i] && rank(i, lp) < lim && rank(i, lp) < br) begin best = i; br = rank(i, lp); end
    return best;
  endfunction

  task automatic model_reset();
    m_state = S_UNINIT; m_lp = 7; m_ack = 0;
    m_ltim = 0; m_sngl = 0; m_ic4 = 0; m_aeoi = 0; m_rot = 0; m_ris = 0;
    m_phase = 0; m_int = 0; m_vv = 0;
    m_icw2 = 0; m_imr = 0; m_isr = 0; m_irr = 0; m_prev = 0; m_vec = 0;
  endtask

  task automatic model_step(input logic w, input logic a, input logic [7:0] d,
                            input logic ia, input logic [7:0] rq);
    int st = m_state;
    int lp_o = m_lp;
    logic ph = m_phase;
    logic aeoi_o = m_aeoi;
    logic rot_o = m_rot;
    logic [7:0] isr_o = m_isr;
    int c = pick(m_irr & ~m_imr, m_isr, m_lp);
    int top = top_isr(m_isr, m_lp);
    int l = int'(d[2:0]);
    logic [7:0] irr_n = m_ltim ? rq : (m_irr | (rq & ~m_prev));
    m_prev = rq;
    m_vv = 0;
    if (w && !a && d[4]) begin
      m_ltim = d[3]; m_sngl = d[1]; m_ic4 = d[0];
      m_imr = 0; m_isr = 0; m_irr = 0; m_aeoi = 0; m_rot = 0; m_lp = 7;
      m_phase = 0; m_int = 0; m_state = S_W2;
    end else begin
      if (w) begin
        case (st)
          S_W2: begin m_icw2 = d; m_state = !m_sngl ? S_W3 : (m_ic4 ? S_W4 : S_RDY); end
          S_W3: m_state = m_ic4 ? S_W4 : S_RDY;
          S_W4: begin m_aeoi = d[1]; m_state = S_RDY; end
          S_RDY: begin
            if (a) m_imr = d;
            else if (d[4:3] == 2'b00) begin
              case (d[7:5])
                3'd1: if (top >= 0) m_isr[top] = 0;
                3'd3: if (isr_o != 0) m_isr[l] = 0;
                3'd5: if (top >= 0) begin m_isr[top] = 0; m_lp = top; end
                3'd7: if (isr_o != 0) begin m_isr[l] = 0; m_lp = l; end
                3'd6: m_lp = l;
                3'd4: m_rot = 1;
                3'd0: m_rot = 0;
                default: ;
              endcase
            end else if (d[4:3] == 2'b01 && d[1]) m_ris = d[0];
          end
          default: ;
        endcase
      end
      if (st == S_RDY && ia) begin
        m_int = 0;
        if (!ph) begin
          m_ack = (c >= 0) ? c : 7;
          if (c >= 0) begin m_isr[c] = 1; irr_n[c] = 0; end
          m_phase = 1;
        end else begin
          m_vec = {m_icw2[7:3], 3'(m_ack)};
          m_vv = 1;
          if (aeoi_o) begin
            m_isr[m_ack] = 0;
            if (rot_o) m_lp = m_ack;
          end
          m_phase = 0;
        end
      end else begin
        m_int = (st == S_RDY) && (c >= 0) && !ph;
      end
      m_irr = irr_n;
    end
  endtask

  task automatic compare_all();
    check("int_out", int_out, m_int);
    check("vector_valid", vector_valid, m_vv);
    check("vector_out", vector_out, m_vec);
    check("isr", isr_out, m_isr);
    check("irr", irr_out, m_irr);
    check("imr", imr_out, m_imr);
    check("init_done", init_done, m_state == S_RDY);
    check("rd_data", rd_data, a0 ? m_imr : (m_ris ? m_isr : m_irr));
    if (vector_valid) $display("[TB] t=%0t INTA vector=%02h isr=%02h", $time, vector_out, isr_out);
  endtask

  // one clock: drive at negedge, model the edge, compare just after posedge
  task automatic cyc(input logic w, input logic a, input logic [7:0] d, input logic ia);
    @(negedge clk);
    reset = 0; wr_stb = w; a0 = a; wr_data = d; inta_stb = ia; irq_req = req_v;
    model_step(w, a, d, ia, req_v);
    @(posedge clk); #1;
    compare_all();
  endtask

  task automatic wr(input logic a, input logic [7:0] d); cyc(1'b1, a, d, 1'b0); endtask
  task automatic inta(); cyc(1'b0, 1'b0, 8'h00, 1'b1); endtask
  task automatic idle(input int n); for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0); endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; wr_stb = 0; a0 = 0; wr_data = 0; inta_stb = 0; irq_req = req_v;
    @(posedge clk); #1;
    model_reset();
    compare_all();
  endtask

  task automatic init_std(input logic [7:0] icw4);
    wr(1'b0, 8'h13); wr(1'b1, 8'h20); wr(1'b1, icw4);
  endtask

  initial begin
    do_reset();
    check("rst_init_done", init_done, 1'b0);
    check("rst_vector", vector_out, 8'h00);
    check("rst_isr", isr_out, 8'h00);

    // basic init, latency and vector
    init_std(8'h01);
    check("init_ready", init_done, 1'b1);
    req_v = 8'h08;
    idle(1); check("lat_cycle1", int_out, 1'b0);
    idle(1); check("lat_cycle2", int_out, 1'b1);
    inta();  check("int_drop", int_out, 1'b0);
    idle(1); inta();
    check("vec_ir3", vector_out, 8'h23);
    check("vv_ir3", vector_valid, 1'b1);
    check("isr_ir3", isr_out, 8'h08);
    idle(1); check("vv_one_cycle", vector_valid, 1'b0);
    wr(1'b0, 8'h20); req_v = 0; idle(1);

    // rotate on non-specific EOI
    init_std(8'h01);
    req_v = 8'h82; idle(2);
    inta(); idle(1); inta();
    check("vec_ir1", vector_out, 8'h21);
    wr(1'b0, 8'hA0);
    check("isr_after_rot_eoi", isr_out, 8'h00);
    req_v = 8'h80; idle(1); req_v = 8'h82; idle(2);
    inta(); idle(1); inta();
    check("vec_ir7_first", vector_out, 8'h27);
    wr(1'b0, 8'h20); req_v = 0; idle(1);

    // AEOI with auto-rotate
    init_std(8'h03);
    wr(1'b0, 8'h80);
    req_v = 8'h20; idle(2);
    inta(); idle(1); inta();
    check("vec_ir5_aeoi", vector_out, 8'h25);
    check("isr_aeoi_clear", isr_out, 8'h00);
    req_v = 8'h70; idle(2);
    inta(); idle(1); inta();
    check("vec_after_autorot", vector_out, 8'h26);
    req_v = 0; idle(1);

    // spurious acknowledge with everything masked
    init_std(8'h01);
    req_v = 8'h04; idle(2);
    wr(1'b1, 8'hFF);
    inta(); idle(1); inta();
    check("vec_spurious", vector_out, 8'h27);
    check("isr_spurious", isr_out, 8'h00);
    req_v = 0; idle(1);

    // ICW1 between the two INTAs
    init_std(8'h01);
    req_v = 8'h02; idle(2);
    inta(); wr(1'b0, 8'h13); inta();
    check("abort_vv", vector_valid, 1'b0);
    check("abort_isr", isr_out, 8'h00);
    check("abort_state", init_done, 1'b0);
    wr(1'b1, 8'h20); wr(1'b1, 8'h01);
    req_v = 0; idle(1);

    // reset in the middle of an INTA sequence
    req_v = 8'h01; idle(2);
    inta();
    do_reset();
    inta(); idle(1); inta();
    check("reset_mid_inta_vv", vector_valid, 1'b0);
    req_v = 0;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic w, a, ia;
      logic [7:0] d;
      r = $urandom_range(0, 99);
      w = 1; a = 0; d = 0;
      if (r < 3)       d = 8'h10 | 8'($urandom & 32'h0B);
      else if (r < 9)  begin a = 1; d = 8'($urandom & $urandom); end
      else if (r < 15) d = {3'($urandom), 2'b00, 3'($urandom)};
      else if (r < 18) d = {3'b000, 2'b01, 3'($urandom)};
      else w = 0;
      ia = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 9) == 0) req_v = req_v ^ (8'h01 << $urandom_range(0, 7));
      cyc(w, a, d, ia);
    end

    // four-channel build
    @(negedge clk); reset = 0; wr_stb4 = 1; a0_4 = 0; wr_data4 = 8'h13;
    @(negedge clk); a0_4 = 1; wr_data4 = 8'h40;
    @(negedge clk); wr_data4 = 8'h01;
    @(negedge clk); wr_stb4 = 0; irq4 = 4'h4;
    repeat (3) @(negedge clk);
    check("n4_int_out", int4, 1'b1);
    inta4 = 1;
    @(negedge clk); inta4 = 0;
    @(negedge clk); inta4 = 1;
    @(posedge clk); #1;
    check("n4_vv", vv4, 1'b1);
    check("n4_vector", vec4, 8'h42);
    check("n4_isr", isr4, 4'h4);
    if (vv4) $display("[TB] t=%0t N4 INTA vector=%02h", $time, vec4);
    @(negedge clk); inta4 = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/intr_sequencer_core.md
INTR_SEQUENCER_CORE -- requirements
Module: intr_sequencer_core

Interface
REQ-001 SHALL have parameter N_IRQ, default 8, number of request channels; legal values 2, 4, 8.
REQ-002 SHALL have parameter IDW, default clog2(N_IRQ), channel-index width.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 wr_stb  in  1  one-cycle command-write strobe.
REQ-006 a0  in  1  command address bit.
REQ-007 wr_data  in  8  command byte.
REQ-008 inta_stb  in  1  one-cycle pulse per INTA bus cycle.
REQ-009 irq_req  in  N_IRQ  synchronised request lines.
REQ-010 int_out  out  1  interrupt request to CPU.
REQ-011 vector_out  out  8  interrupt vector.
REQ-012 vector_valid  out  1  one-cycle qualifier for vector_out.
REQ-013 rd_data  out  8  status readback, zero-extended.
REQ-014 imr_out / isr_out / irr_out  out  N_IRQ  mask, in-service and request registers.
REQ-015 init_done  out  1  high when the init FSM is in READY.

Function
REQ-016 Init FSM states: UNINIT, W_ICW2, W_ICW3, W_ICW4, READY.
REQ-017 A write with a0=0 and wr_data[4]=1 is ICW1 in any state.
- ICW1 stores LTIM=d[3], SNGL=d[1], IC4=d[0].
- ICW1 clears IMR, ISR, IRR, AEOI and auto_rotate, sets lowest_prio=N_IRQ-1, aborts any INTA sequence, and enters W_ICW2.
REQ-018 Init sequencing:
- W_ICW2: any write stores ICW2.
- Next state is W_ICW3 if SNGL=0, else W_ICW4 if IC4=1, else READY.
- W_ICW3: write is stored and ignored; next state is W_ICW4 if IC4=1, else READY.
- W_ICW4: AEOI=d[1], then READY.
REQ-019 READY writes:
- a0=1: OCW1; IMR=d[N_IRQ-1:0].
- a0=0, d[4:3]=00: OCW2.
- a0=0, d[4:3]=01: OCW3; RIS=d[0] is stored only when d[1]=1.
REQ-020 OCW2 d[7:5] decode, where L=d[IDW-1:0]:
- 001: clear the highest-priority ISR bit.
- 011: clear ISR[L].
- 101: clear the highest-priority ISR bit and set lowest_prio to that index.
- 111: clear ISR[L] and set lowest_prio=L.
- 110: set lowest_prio=L.
- 100: set auto_rotate.
- 000: clear auto_rotate.
- 010: no operation.
- An EOI with ISR all zero changes nothing.
REQ-021 IRR capture:
- LTIM=0: IRR bit is set on a 0->1 transition of irq_req.
- LTIM=1: IRR bit is set while irq_req is high.
- An IRR bit is cleared when its channel is acknowledged, or in LTIM=1 when irq_req falls.
REQ-022 Priority order: channel (lowest_prio+1) mod N_IRQ is highest, with wrap-around.
- Candidate: the highest-priority bit of IRR & ~IMR that ranks strictly above every set ISR bit.
REQ-023 int_out is registered.
- It is high one cycle after a candidate exists, outside an INTA sequence, when init_done=1.
- It drops in the cycle after the first inta_stb.
- Latency from irq_req rising edge to int_out is 2 cycles.
REQ-024 First inta_stb:
- Latch the candidate index into ack_id, set ISR[ack_id], clear IRR[ack_id].
- If there is no candidate, set ack_id=N_IRQ-1 as the spurious case and change no ISR bit.
REQ-025 Second inta_stb:
- vector_out={ICW2[7:IDW], ack_id} and vector_valid=1 for exactly one cycle.
- If AEOI=1, clear ISR[ack_id]; if AEOI=1 and auto_rotate=1, also set lowest_prio=ack_id.
REQ-026 inta_stb before init_done is ignored.
- A third inta_stb without an intervening int_out starts a new sequence.
REQ-027 Simultaneous events:
- OCW2 EOI in the same cycle as an ISR set: the clear applies first and the set wins on the same bit.
- ICW1 in the same cycle as inta_stb: ICW1 wins.
REQ-028 rd_data outputs:
- a0=1: IMR.
- a0=0 and RIS=1: ISR.
- a0=0 and RIS=0: IRR.

Reset
REQ-029 On reset:
- FSM=UNINIT; IMR, ISR and IRR are 0.
- lowest_prio=N_IRQ-1; ICW regs, AEOI, auto_rotate and RIS are 0.
- int_out=0, vector_out=0, vector_valid=0, init_done=0.
REQ-030 Reset mid-INTA sequence discards the sequence; no vector_valid is produced.

Verification
REQ-031 Init 0x13 (SNGL, IC4), 0x20, 0x01; raise irq_req[3] -> int_out 2 cycles later; two INTAs -> vector 0x23, ISR=0x08.
REQ-032 Requests 0x82 pending, ISR=0; non-specific EOI with rotate on IR1 -> lowest_prio=1; next ack selects IR7 before IR1.
REQ-033 AEOI=1, auto_rotate on, ack IR5 -> ISR returns 0 after second INTA; lowest_prio=5.
REQ-034 IMR=0xFF with a request pending, INTA pulses issued -> vector {ICW2[7:3],7}; ISR unchanged.
REQ-035 ICW1 written between the two INTAs -> no vector_valid, ISR=0, FSM=W_ICW2.
REQ-036 N_IRQ=4 build, ICW2=0x40, ack IR2 -> vector 0x42.
